// File: rtl/alu_test_seq.sv
// Randomised test-vector sequencer for a modular-arithmetic ALU: draws operands below the
// selected field modulus from a xorshift64 stream, issues one operation per vector, tallies results.
module alu_test_seq #(
  parameter logic [255:0] P_ALT   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter int unsigned  TIMEOUT = 20000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  n_vec,
  input  logic [63:0]  seed,
  input  logic [1:0]   op_sel,
  input  logic         fld_in,
  output logic         test_add,
  output logic         test_sub,
  output logic         test_mul,
  output logic         test_inv,
  output logic         run,
  output logic         fld_25519,
  output logic [255:0] opa,
  output logic [255:0] opb,
  input  logic         pass,
  input  logic         done,
  input  logic         bad_op,
  output logic         busy,
  output logic         finished,
  output logic [15:0]  vec_cnt,
  output logic [15:0]  fail_cnt,
  output logic         timeout_err,
  output logic         bad_op_seen
);

  localparam logic [255:0] P_25519 = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
  localparam logic [1:0]   OP_INV  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_GEN_A, S_CHK_A, S_GEN_B, S_CHK_B, S_ISSUE, S_WAIT, S_FINISH
  } state_t;

  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] v;
    v = x ^ (x << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  function automatic logic [3:0] op_onehot(input logic [1:0] op);
    logic [3:0] oh;
    case (op)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  state_t         state_r;
  logic [63:0]    prng_r;
  logic [1:0]     gen_idx_r;
  logic [255:0]   opa_r, opb_r;
  logic [15:0]    n_vec_r, vec_cnt_r, fail_cnt_r;
  logic [1:0]     op_r;
  logic           fld_r, run_r, busy_r, finished_r, timeout_err_r, bad_op_seen_r;
  logic [3:0]     strobe_r;
  logic [31:0]    wait_cnt_r;

  logic [63:0]    prng_next_s;
  logic [255:0]   mod_s, cand_a_s, cand_b_s;
  logic           reject_a_s, reject_b_s, timeout_hit_s, last_vec_s, vec_fail_s;

  // Candidate masking, rejection tests and WAIT exit decode.
  always_comb begin
    prng_next_s = xorshift64(prng_r);
    cand_a_s    = opa_r;
    cand_b_s    = opb_r;
    if (fld_r) begin
      mod_s         = P_25519;
      cand_a_s[255] = 1'b0;
      cand_b_s[255] = 1'b0;
    end else begin
      mod_s = P_ALT;
    end
    reject_a_s    = (cand_a_s >= mod_s) || ((op_r == OP_INV) && (cand_a_s == 256'd0));
    reject_b_s    = (cand_b_s >= mod_s);
    // A done arriving on the timeout cycle wins over the timeout.
    timeout_hit_s = !done && (wait_cnt_r >= TIMEOUT);
    last_vec_s    = (({1'b0, vec_cnt_r} + 17'd1) == {1'b0, n_vec_r});
    vec_fail_s    = (done && (!pass || bad_op)) || timeout_hit_s;
  end

  // Campaign sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      prng_r        <= 64'h1;
      gen_idx_r     <= 2'd0;
      opa_r         <= 256'd0;
      opb_r         <= 256'd0;
      n_vec_r       <= 16'd0;
      vec_cnt_r     <= 16'd0;
      fail_cnt_r    <= 16'd0;
      op_r          <= 2'd0;
      fld_r         <= 1'b0;
      run_r         <= 1'b0;
      busy_r        <= 1'b0;
      finished_r    <= 1'b0;
      timeout_err_r <= 1'b0;
      bad_op_seen_r <= 1'b0;
      strobe_r      <= 4'b0000;
      wait_cnt_r    <= 32'd0;
    end else begin
      finished_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            vec_cnt_r     <= 16'd0;
            fail_cnt_r    <= 16'd0;
            timeout_err_r <= 1'b0;
            bad_op_seen_r <= 1'b0;
            n_vec_r       <= n_vec;
            op_r          <= op_sel;
            fld_r         <= fld_in;
            prng_r        <= (seed == 64'd0) ? 64'h1 : seed;
            gen_idx_r     <= 2'd0;
            busy_r        <= 1'b1;
            state_r       <= (n_vec == 16'd0) ? S_FINISH : S_GEN_A;
          end
        end
        S_GEN_A: begin
          prng_r                          <= prng_next_s;
          opa_r[{gen_idx_r, 6'd0} +: 64] <= prng_next_s;
          gen_idx_r                       <= gen_idx_r + 2'd1;
          if (gen_idx_r == 2'd3) state_r <= S_CHK_A;
        end
        S_CHK_A: begin
          opa_r   <= cand_a_s;
          state_r <= reject_a_s ? S_GEN_A : S_GEN_B;
        end
        S_GEN_B: begin
          prng_r                          <= prng_next_s;
          opb_r[{gen_idx_r, 6'd0} +: 64] <= prng_next_s;
          gen_idx_r                       <= gen_idx_r + 2'd1;
          if (gen_idx_r == 2'd3) state_r <= S_CHK_B;
        end
        S_CHK_B: begin
          opb_r <= cand_b_s;
          if (reject_b_s) begin
            state_r <= S_GEN_B;
          end else begin
            run_r    <= 1'b1;
            strobe_r <= op_onehot(op_r);
            state_r  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          run_r      <= 1'b0;
          wait_cnt_r <= 32'd1;
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          if (done || timeout_hit_s) begin
            strobe_r <= 4'b0000;
            if (vec_cnt_r != 16'hFFFF) vec_cnt_r <= vec_cnt_r + 16'd1;
            if (vec_fail_s && (fail_cnt_r != 16'hFFFF)) fail_cnt_r <= fail_cnt_r + 16'd1;
            if (bad_op) bad_op_seen_r <= 1'b1;
            if (timeout_hit_s) timeout_err_r <= 1'b1;
            state_r <= last_vec_s ? S_FINISH : S_GEN_A;
          end else begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
          end
        end
        S_FINISH: begin
          finished_r <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= S_IDLE;
        end
        default: begin
          run_r    <= 1'b0;
          strobe_r <= 4'b0000;
          busy_r   <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

  assign test_add    = strobe_r[0];
  assign test_sub    = strobe_r[1];
  assign test_mul    = strobe_r[2];
  assign test_inv    = strobe_r[3];
  assign run         = run_r;
  assign fld_25519   = fld_r;
  assign opa         = opa_r;
  assign opb         = opb_r;
  assign busy        = busy_r;
  assign finished    = finished_r;
  assign vec_cnt     = vec_cnt_r;
  assign fail_cnt    = fail_cnt_r;
  assign timeout_err = timeout_err_r;
  assign bad_op_seen = bad_op_seen_r;

endmodule

// File: tb/tb_alu_test_seq.sv
// Directed bench for alu_test_seq: a reference xorshift operand model and a scripted ALU
// responder drive each campaign; every comparison is an immediate assertion.
module tb_alu_test_seq;

  localparam logic [255:0] P_25519 = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
  localparam logic [255:0] P_ALT   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, fld_in = 1'b0;
  logic [15:0] n_vec = 16'd0;
  logic [63:0] seed = 64'd0;
  logic [1:0] op_sel = 2'd0;
  logic pass = 1'b0, done = 1'b0, bad_op = 1'b0;
  logic test_add, test_sub, test_mul, test_inv, run, fld_25519, busy, finished;
  logic timeout_err, bad_op_seen;
  logic [255:0] opa, opb;
  logic [15:0] vec_cnt, fail_cnt;
  wire  [3:0]  strobes = {test_inv, test_mul, test_sub, test_add};

  int n_assert = 0;
  int n_fail = 0;

  logic [63:0] m_prng;
  logic [1:0]  m_op;
  logic        m_fld;
  int          exp_vec, exp_fail;
  logic        exp_to, exp_bad;

  alu_test_seq #(.TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .start(start), .n_vec(n_vec), .seed(seed), .op_sel(op_sel),
    .fld_in(fld_in), .test_add(test_add), .test_sub(test_sub), .test_mul(test_mul),
    .test_inv(test_inv), .run(run), .fld_25519(fld_25519), .opa(opa), .opb(opb),
    .pass(pass), .done(done), .bad_op(bad_op), .busy(busy), .finished(finished),
    .vec_cnt(vec_cnt), .fail_cnt(fail_cnt), .timeout_err(timeout_err), .bad_op_seen(bad_op_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xs64(input logic [63:0] x);
    logic [63:0] v;
    v = x ^ (x << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  // Draws one operand from the model stream, retrying exactly as the sequencer must.
  function automatic logic [255:0] gen_operand(input bit is_a);
    logic [255:0] v;
    logic [255:0] p;
    bit ok;
    p  = m_fld ? P_25519 : P_ALT;
    ok = 1'b0;
    v  = 256'd0;
    while (!ok) begin
      for (int w = 0; w < 4; w++) begin
        m_prng = xs64(m_prng);
        v[w*64 +: 64] = m_prng;
      end
      if (m_fld) v[255] = 1'b0;
      ok = (v < p) && !(is_a && (m_op == 2'd3) && (v == 256'd0));
    end
    return v;
  endfunction

  task automatic start_campaign(input logic [15:0] nv, input logic [63:0] sd,
                                input logic [1:0] op, input logic fld);
    @(negedge clk);
    start = 1'b1; n_vec = nv; seed = sd; op_sel = op; fld_in = fld;
    m_prng = (sd == 64'd0) ? 64'h1 : sd;
    m_op = op; m_fld = fld;
    exp_vec = 0; exp_fail = 0; exp_to = 1'b0; exp_bad = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 256'(busy), 256'd1);
    chk("vec_cnt_cleared", 256'(vec_cnt), 256'd0);
    chk("fail_cnt_cleared", 256'(fail_cnt), 256'd0);
  endtask

  // lat < 0 means the ALU never answers; poke pulses start mid-WAIT to prove it is ignored.
  task automatic do_vec(input int lat, input logic pass_v, input logic bad_v, input bit poke);
    logic [255:0] ea, eb;
    logic [3:0] es;
    int waited;
    bit seen;
    bit to;
    ea = gen_operand(1'b1);
    eb = gen_operand(1'b0);
    es = 4'b0001 << m_op;
    seen = 1'b0;
    waited = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      waited = i;
      if (run === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("run_seen", 256'(seen), 256'd1);
    if (!seen) return;
    chk("run_latency", 256'(waited), 256'd10);
    chk("opa", opa, ea);
    chk("opb", opb, eb);
    chk("strobe_at_run", 256'(strobes), 256'(es));
    chk("fld_25519", 256'(fld_25519), 256'(m_fld));
    if (m_fld) begin
      chk("opa_bit255", 256'(opa[255]), 256'd0);
      chk("opb_bit255", 256'(opb[255]), 256'd0);
      chk("opa_below_p", 256'(opa < P_25519), 256'd1);
      chk("opb_below_p", 256'(opb < P_25519), 256'd1);
    end
    if (m_op == 2'd3) chk("opa_nonzero", 256'(opa != 256'd0), 256'd1);
    @(negedge clk);
    chk("run_one_cycle", 256'(run), 256'd0);
    chk("strobe_hold", 256'(strobes), 256'(es));
    chk("opa_hold", opa, ea);
    to = (lat < 0);
    if (to) begin
      for (int k = 2; k <= 50; k++) begin
        @(negedge clk);
        if (poke && (k == 5)) begin
          start = 1'b1; n_vec = 16'd1; seed = 64'd5; op_sel = 2'd0;
        end else begin
          start = 1'b0;
        end
      end
      chk("timeout_strobe_still_high", 256'(strobes), 256'(es));
      chk("timeout_vec_not_yet", 256'(vec_cnt), 256'(exp_vec));
    end else begin
      repeat (lat - 1) @(negedge clk);
      chk("wait_strobe_before_done", 256'(strobes), 256'(es));
      done = 1'b1; pass = pass_v; bad_op = bad_v;
    end
    @(negedge clk);
    done = 1'b0; pass = 1'b0; bad_op = 1'b0;
    exp_vec++;
    if (to || !pass_v || bad_v) exp_fail++;
    if (to) exp_to = 1'b1;
    if (!to && bad_v) exp_bad = 1'b1;
    chk("vec_cnt", 256'(vec_cnt), 256'(exp_vec));
    chk("fail_cnt", 256'(fail_cnt), 256'(exp_fail));
    chk("timeout_err", 256'(timeout_err), 256'(exp_to));
    chk("bad_op_seen", 256'(bad_op_seen), 256'(exp_bad));
    chk("strobe_cleared", 256'(strobes), 256'd0);
  endtask

  // Called one cycle after the final WAIT exit (or one cycle after an n_vec=0 start).
  task automatic finish_check();
    chk("fin_not_yet", 256'(finished), 256'd0);
    chk("fin_busy_before", 256'(busy), 256'd1);
    @(negedge clk);
    chk("fin_pulse", 256'(finished), 256'd1);
    chk("fin_busy_low", 256'(busy), 256'd0);
    chk("fin_no_run", 256'(run), 256'd0);
    @(negedge clk);
    chk("fin_one_cycle", 256'(finished), 256'd0);
    @(negedge clk);
    chk("idle_vec_hold", 256'(vec_cnt), 256'(exp_vec));
    chk("idle_fail_hold", 256'(fail_cnt), 256'(exp_fail));
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_run"}, 256'(run), 256'd0);
    chk({tag, "_strobes"}, 256'(strobes), 256'd0);
    chk({tag, "_busy"}, 256'(busy), 256'd0);
    chk({tag, "_finished"}, 256'(finished), 256'd0);
    chk({tag, "_vec"}, 256'(vec_cnt), 256'd0);
    chk({tag, "_fail"}, 256'(fail_cnt), 256'd0);
    chk({tag, "_to"}, 256'(timeout_err), 256'd0);
    chk({tag, "_bad"}, 256'(bad_op_seen), 256'd0);
    chk({tag, "_opa"}, opa, 256'd0);
    chk({tag, "_opb"}, opb, 256'd0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    reset_values("reset");
    rst = 1'b0;

    // Three add vectors, ALU answers pass after 10 cycles.
    start_campaign(16'd3, 64'd1, 2'd0, 1'b0);
    do_vec(10, 1'b1, 1'b0, 1'b0);
    do_vec(10, 1'b1, 1'b0, 1'b0);
    do_vec(10, 1'b1, 1'b0, 1'b0);
    finish_check();

    // Four mul vectors, second one fails.
    start_campaign(16'd4, 64'h0123_4567_89AB_CDEF, 2'd2, 1'b0);
    do_vec(10, 1'b1, 1'b0, 1'b0);
    do_vec(10, 1'b0, 1'b0, 1'b0);
    do_vec(10, 1'b1, 1'b0, 1'b0);
    do_vec(10, 1'b1, 1'b0, 1'b0);
    finish_check();

    // Silent ALU: both sub vectors time out; a start during WAIT is ignored.
    start_campaign(16'd2, 64'hCAFE, 2'd1, 1'b0);
    do_vec(-1, 1'b0, 1'b0, 1'b1);
    do_vec(-1, 1'b0, 1'b0, 1'b0);
    finish_check();

    // Curve25519 field, inversion, second vector reports bad_op.
    start_campaign(16'd2, 64'hFEED_FACE_1234_5678, 2'd3, 1'b1);
    do_vec(3, 1'b1, 1'b0, 1'b0);
    do_vec(3, 1'b1, 1'b1, 1'b0);
    finish_check();

    // Empty campaign.
    start_campaign(16'd0, 64'd7, 2'd0, 1'b0);
    finish_check();

    // Zero seed must reproduce the seed=1 operand stream.
    start_campaign(16'd1, 64'd0, 2'd0, 1'b0);
    do_vec(10, 1'b1, 1'b0, 1'b0);
    finish_check();

    // Reset during WAIT aborts silently, then a fresh single-vector campaign.
    start_campaign(16'd2, 64'd1, 2'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (run === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_run_seen", 256'(seen), 256'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_values("midwait_reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_finished", 256'(finished), 256'd0);
    end
    start_campaign(16'd1, 64'd1, 2'd0, 1'b0);
    do_vec(10, 1'b1, 1'b0, 1'b0);
    finish_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
